puf_eval_ctrl: RTL and testbench
================================

// Module: puf_eval_ctrl
// PURPOSE
//  Evaluation controller that sits directly upstream of the arbiter PUF array and consumes its output.
//  - Accepts a challenge over a valid/ready handshake and holds it on the PUF challenge bus.
//  - Launches VOTES race evaluations by discharging and then firing the PUF signal line.
//  - Synchronises and samples the N-bit arbiter response after each firing.
//  - Majority-votes each bit across all evaluations and returns the stable response over valid/ready.
// PARAMETERS
//  N       128  challenge/response width; matches the PUF array width.
//  SETTLE  8    cycles per signal phase (low discharge, high race). Must be >= 3.
//  VOTES   5    evaluations per challenge. Must be odd and >= 1.
//  CW      $clog2(VOTES+1)  per-bit vote counter width (derived, not overridable).
// PORTS
//  clk            in   1  single clock; all state is on the rising edge.
//  rst            in   1  asynchronous, active-high reset.
//  chal_valid     in   1  upstream challenge valid.
//  chal_ready     out  1  high only in IDLE.
//  chal_in        in   N  challenge; captured on chal_valid && chal_ready.
//  puf_challenge  out  N  registered challenge driven to the PUF array.
//  puf_signal     out  1  registered race launch line to the PUF array.
//  puf_response   in   N  raw arbiter outputs; asynchronous to clk.
//  resp_valid     out  1  voted response available.
//  resp_ready     in   1  downstream accepts the response.
//  resp_out       out  N  majority-voted response.
//  busy           out  1  high in every state except IDLE.
// BEHAVIOUR
//  Reset (async assert, sync release): all outputs are 0 except chal_ready=1.
//   puf_challenge=0, puf_signal=0, resp_valid=0, resp_out=0; counters and state cleared.
//  FSM states:
//   - IDLE: chal_ready=1. On handshake, capture chal_in into puf_challenge, clear vote counters and vote index, go to PRE.
//   - PRE: puf_signal=0 for SETTLE cycles, then go to FIRE.
//   - FIRE: puf_signal=1 for SETTLE cycles, then go to SAMPLE.
//   - SAMPLE: 1 cycle with puf_signal held 1.
//     - cnt[i] += sync_resp[i] for all i.
//     - If vote index = VOTES-1, go to DONE; otherwise increment the index and go to PRE.
//   - DONE: resp_out[i] = (cnt[i] > VOTES/2), registered on entry to DONE. resp_valid=1, puf_signal=0.
//     On resp_ready, go to IDLE. resp_valid and resp_out are held stable until then.
//  Synchronisation:
//   - puf_response passes through a 2-flop synchroniser that runs continuously.
//   - SETTLE>=3 guarantees the synchroniser output reflects the settled race in SAMPLE.
//  Latency: resp_valid rises exactly VOTES*(2*SETTLE+1)+1 rising edges after the accepting edge (86 with defaults).
//  puf_challenge changes only on a chal handshake; it is stable through every evaluation.
//  chal_valid outside IDLE is ignored; chal_ready=0, so there is no capture.
//  DONE->IDLE takes one edge. The earliest next challenge is accepted on the edge after the resp handshake.
//  A combinational ready path from resp_ready to chal_ready is forbidden.
//  Vote counters cannot overflow: CW bits hold VOTES. Compare against the constant VOTES/2 (integer divide).
//  Reset mid-operation:
//   - puf_signal drops to 0 immediately and the partial vote is discarded.
//   - No resp_valid is produced for the aborted challenge.
//  Elaboration check: fatal if VOTES is even or SETTLE < 3.
// STRUCTURE
//  Shared package puf_pkg:
//   - State enum (IDLE, PRE, FIRE, SAMPLE, DONE).
//   - Default constants PUF_N=128, PUF_SETTLE=8, PUF_VOTES=5.
//  Sub-module puf_sync2: N-bit 2-flop synchroniser on clk with async rst.
//  Phase counter, vote index and vote counters live in puf_eval_ctrl.
// TESTING
//  1. Assert rst mid-clock -> outputs go to reset values immediately; chal_ready=1 after release.
//  2. Response model returns all-ones; send chal 0xA5..A5 -> resp_valid at edge 86, resp_out=all-ones.
//     puf_challenge=0xA5..A5 stable throughout.
//  3. Model bit0=1 in 3 of 5 votes, bit1=1 in 2 of 5, bit2=1 in 5 of 5 -> resp_out[2:0]=3'b101.
//  4. Hold resp_ready=0 for 20 cycles after resp_valid -> resp_out stable, chal_ready=0, chal_valid ignored.
//     Accept next challenge 2 edges after resp_ready.
//  5. Pulse rst at edge 40 of an evaluation -> puf_signal=0 at once; no resp_valid for that challenge.
//     A new challenge then completes normally.
//  6. Waveform check, each vote: puf_signal low 8 cycles, high 9 cycles (8 FIRE + 1 SAMPLE); exactly 5 cycles.

Source files
------------

// File: rtl/puf_pkg.sv
// Shared types and default sizing for the arbiter-PUF evaluation controller.
package puf_pkg;

  localparam int PUF_N      = 128;
  localparam int PUF_SETTLE = 8;
  localparam int PUF_VOTES  = 5;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    FIRE,
    SAMPLE,
    DONE
  } puf_state_e;

endpackage

// File: rtl/puf_eval_ctrl_if.sv
// Challenge-in / response-out handshake bundle between a host and puf_eval_ctrl.
interface puf_eval_ctrl_if #(
  parameter int N = puf_pkg::PUF_N
);

  logic         chal_valid;
  logic         chal_ready;
  logic [N-1:0] chal_in;
  logic         resp_valid;
  logic         resp_ready;
  logic [N-1:0] resp_out;

  // master is the host that issues challenges and consumes responses
  modport master (
    output chal_valid, chal_in, resp_ready,
    input  chal_ready, resp_valid, resp_out
  );

  modport slave (
    input  chal_valid, chal_in, resp_ready,
    output chal_ready, resp_valid, resp_out
  );

endinterface

// File: rtl/puf_sync2.sv
// Free-running N-bit two-flop synchroniser for the asynchronous arbiter outputs.
module puf_sync2 #(
  parameter int N = puf_pkg::PUF_N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] d_i,
  output logic [N-1:0] q_o
);

  logic [N-1:0] meta_q;
  logic [N-1:0] sync_q;

  // NOTE: non-blocking assignments let both flops sample the pre-edge values,
  // giving a true two-stage chain rather than a single collapsed flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/puf_eval_ctrl.sv
// Arbiter-PUF evaluation controller: holds a challenge, fires VOTES races,
// majority-votes the synchronised responses and returns the stable result.
module puf_eval_ctrl
  import puf_pkg::*;
#(
  parameter int N      = PUF_N,
  parameter int SETTLE = PUF_SETTLE,
  parameter int VOTES  = PUF_VOTES
) (
  input  logic           clk,
  input  logic           rst,
  puf_eval_ctrl_if.slave bus,
  output logic [N-1:0]   puf_challenge,
  output logic           puf_signal,
  input  logic [N-1:0]   puf_response,
  output logic           busy
);

  localparam int CW = $clog2(VOTES + 1);
  localparam int PW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int VW = (VOTES > 1) ? $clog2(VOTES) : 1;

  localparam logic [PW-1:0] PHASE_LAST = PW'(SETTLE - 1);
  localparam logic [VW-1:0] VOTE_LAST  = VW'(VOTES - 1);
  localparam logic [CW-1:0] HALF_VOTES = CW'(VOTES / 2);

  if ((VOTES % 2) == 0 || VOTES < 1 || SETTLE < 3) begin : g_param_check
    $fatal(1, "puf_eval_ctrl: VOTES must be odd and >= 1, SETTLE must be >= 3");
  end

  puf_state_e    state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [VW-1:0] vote_q, vote_d;
  logic [CW-1:0] cnt_q [N];
  logic [CW-1:0] cnt_d [N];
  logic [N-1:0]  chal_q, chal_d;
  logic [N-1:0]  resp_q, resp_d;
  logic          valid_q, valid_d;
  logic          sig_q, sig_d;
  logic [N-1:0]  sync_resp;

  puf_sync2 #(.N(N)) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (puf_response),
    .q_o (sync_resp)
  );

  // NOTE: every variable gets its hold value before the case statement so that
  // no path through this block leaves one unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    vote_d  = vote_q;
    cnt_d   = cnt_q;
    chal_d  = chal_q;
    resp_d  = resp_q;
    valid_d = valid_q;

    unique case (state_q)
      IDLE: begin
        if (bus.chal_valid) begin
          chal_d  = bus.chal_in;
          phase_d = '0;
          vote_d  = '0;
          for (int i = 0; i < N; i++) cnt_d[i] = '0;
          state_d = PRE;
        end
      end

      PRE: begin
        if (phase_q == PHASE_LAST) begin
          phase_d = '0;
          state_d = FIRE;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end

      FIRE: begin
        if (phase_q == PHASE_LAST) begin
          phase_d = '0;
          state_d = SAMPLE;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end

      SAMPLE: begin
        for (int i = 0; i < N; i++) cnt_d[i] = cnt_q[i] + CW'(sync_resp[i]);
        if (vote_q == VOTE_LAST) begin
          // Vote uses the counts including this final sample.
          for (int i = 0; i < N; i++) resp_d[i] = (cnt_d[i] > HALF_VOTES);
          state_d = DONE;
        end else begin
          vote_d  = vote_q + 1'b1;
          state_d = PRE;
        end
      end

      DONE: begin
        // resp_out settles on entry; valid follows one edge later.
        if (!valid_q) begin
          valid_d = 1'b1;
        end else if (bus.resp_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    sig_d = (state_d == FIRE) || (state_d == SAMPLE);
  end

  // NOTE: the vote counters are a register array but are still reset, so an
  // aborted evaluation can never leak partial counts into the next one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      phase_q <= '0;
      vote_q  <= '0;
      chal_q  <= '0;
      resp_q  <= '0;
      valid_q <= 1'b0;
      sig_q   <= 1'b0;
      for (int i = 0; i < N; i++) cnt_q[i] <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      vote_q  <= vote_d;
      chal_q  <= chal_d;
      resp_q  <= resp_d;
      valid_q <= valid_d;
      sig_q   <= sig_d;
      cnt_q   <= cnt_d;
    end
  end

  // chal_ready depends only on state, never on resp_ready.
  assign bus.chal_ready = (state_q == IDLE);
  assign bus.resp_valid = valid_q;
  assign bus.resp_out   = resp_q;
  assign busy           = (state_q != IDLE);
  assign puf_challenge  = chal_q;
  assign puf_signal     = sig_q;

endmodule

// File: tb/tb_puf_eval_ctrl.sv
// Self-checking bench for puf_eval_ctrl: per-vote response tables, a majority
// model feeding a scoreboard queue, and timing/waveform checks.
module tb_puf_eval_ctrl;
  import puf_pkg::*;

  localparam int N       = PUF_N;
  localparam int SETTLE  = PUF_SETTLE;
  localparam int VOTES   = PUF_VOTES;
  localparam int LATENCY = VOTES * (2 * SETTLE + 1) + 1;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] puf_challenge;
  logic         puf_signal;
  logic [N-1:0] puf_response;
  logic         busy;

  int checks   = 0;
  int failures = 0;

  logic [N-1:0] tab [VOTES];
  logic [N-1:0] exp_q [$];

  puf_eval_ctrl_if #(.N(N)) bus ();

  puf_eval_ctrl #(.N(N), .SETTLE(SETTLE), .VOTES(VOTES)) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus.slave),
    .puf_challenge (puf_challenge),
    .puf_signal    (puf_signal),
    .puf_response  (puf_response),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] vote_model();
    logic [N-1:0] r;
    int ones;
    for (int b = 0; b < N; b++) begin
      ones = 0;
      for (int v = 0; v < VOTES; v++) ones += int'(tab[v][b]);
      r[b] = (ones > VOTES / 2);
    end
    return r;
  endfunction

  function automatic logic [N-1:0] rand_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Presents a challenge at the next edge; returns #1 after the accepting edge.
  task automatic send_chal(input logic [N-1:0] c);
    int waited;
    waited = 0;
    @(negedge clk);
    while (bus.chal_ready !== 1'b1 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (bus.chal_ready !== 1'b1) begin
      failures++;
      $display("FAIL send_ready_timeout: chal_ready=%b required 1", bus.chal_ready);
    end
    puf_response   = tab[0];
    bus.chal_in    = c;
    bus.chal_valid = 1'b1;
    exp_q.push_back(vote_model());
    @(posedge clk);
    #1 bus.chal_valid = 1'b0;
  endtask

  // Follows one evaluation from the accepting edge to resp_valid, switching the
  // response table per vote and checking phase widths, latency and the result.
  task automatic monitor_eval(input logic [N-1:0] c, output logic [N-1:0] got);
    int lat, run, vote;
    logic prev;
    logic [N-1:0] expv;
    lat = -1; run = 0; vote = 0; prev = 1'b0; got = '0;
    for (int e = 0; e < LATENCY + 20; e++) begin
      @(negedge clk);
      checks++;
      if (puf_challenge !== c) begin
        failures++;
        $display("FAIL chal_stable e=%0d: got %h required %h", e, puf_challenge, c);
      end
      if (bus.resp_valid === 1'b1) begin
        lat = e;
        break;
      end
      checks++;
      if ({busy, bus.chal_ready} !== 2'b10) begin
        failures++;
        $display("FAIL busy_ready e=%0d: got %b required 10", e, {busy, bus.chal_ready});
      end
      if (puf_signal !== prev) begin
        checks++;
        if (prev) begin
          if (run !== SETTLE + 1) begin
            failures++;
            $display("FAIL high_width vote=%0d: got %0d required %0d", vote, run, SETTLE + 1);
          end
          vote++;
          if (vote < VOTES) puf_response = tab[vote];
        end else if (run !== SETTLE) begin
          failures++;
          $display("FAIL low_width vote=%0d: got %0d required %0d", vote, run, SETTLE);
        end
        run  = 1;
        prev = puf_signal;
      end else begin
        run++;
      end
      @(posedge clk);
    end
    checks++;
    if (lat !== LATENCY) begin
      failures++;
      $display("FAIL latency: got %0d required %0d", lat, LATENCY);
    end
    if (lat >= 0) begin
      checks++;
      if (vote !== VOTES) begin
        failures++;
        $display("FAIL vote_count: got %0d required %0d", vote, VOTES);
      end
      got = bus.resp_out;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_resp: got %h required none", got);
      end else begin
        expv = exp_q.pop_front();
        if (got !== expv) begin
          failures++;
          $display("FAIL resp_out: got %h required %h", got, expv);
        end
      end
    end
  endtask

  task automatic take_resp();
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1 bus.resp_ready = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.resp_valid, bus.chal_ready, busy} !== 3'b010) begin
      failures++;
      $display("FAIL resp_handshake: got %b required 010", {bus.resp_valid, bus.chal_ready, busy});
    end
  endtask

  task automatic test_reset();
    bus.chal_valid = 1'b0;
    bus.chal_in    = '0;
    bus.resp_ready = 1'b0;
    puf_response   = '0;
    #3 rst = 1'b1;
    #1;
    checks++;
    if ({puf_signal, bus.resp_valid, busy, bus.chal_ready} !== 4'b0001) begin
      failures++;
      $display("FAIL reset_ctrl: got %b required 0001", {puf_signal, bus.resp_valid, busy, bus.chal_ready});
    end
    checks++;
    if ({puf_challenge, bus.resp_out} !== '0) begin
      failures++;
      $display("FAIL reset_buses: got %h/%h required 0/0", puf_challenge, bus.resp_out);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.chal_ready, busy} !== 2'b10) begin
      failures++;
      $display("FAIL reset_release: got %b required 10", {bus.chal_ready, busy});
    end
  endtask

  task automatic test_all_ones();
    logic [N-1:0] c, got;
    c = {(N / 8){8'hA5}};
    for (int v = 0; v < VOTES; v++) tab[v] = '1;
    send_chal(c);
    monitor_eval(c, got);
    checks++;
    if (got !== '1) begin
      failures++;
      $display("FAIL all_ones: got %h required all-ones", got);
    end
    take_resp();
  endtask

  task automatic test_majority();
    logic [N-1:0] c, got;
    c = rand_word();
    for (int v = 0; v < VOTES; v++) begin
      tab[v]    = rand_word();
      tab[v][0] = (v % 2 == 0);
      tab[v][1] = (v % 2 == 1);
      tab[v][2] = 1'b1;
    end
    send_chal(c);
    monitor_eval(c, got);
    checks++;
    if (got[2:0] !== 3'b101) begin
      failures++;
      $display("FAIL majority_low_bits: got %b required 101", got[2:0]);
    end
    take_resp();
  endtask

  task automatic test_random();
    logic [N-1:0] c, got;
    for (int k = 0; k < 3; k++) begin
      c = rand_word();
      for (int v = 0; v < VOTES; v++) tab[v] = rand_word();
      send_chal(c);
      monitor_eval(c, got);
      take_resp();
    end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] c1, c2, hold, got;
    c1 = rand_word();
    c2 = ~c1;
    for (int v = 0; v < VOTES; v++) tab[v] = rand_word();
    hold = vote_model();
    send_chal(c1);
    monitor_eval(c1, got);
    bus.chal_valid = 1'b1;
    bus.chal_in    = c2;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if ({bus.resp_valid, bus.chal_ready, busy, puf_signal} !== 4'b1010 ||
          bus.resp_out !== hold || puf_challenge !== c1) begin
        failures++;
        $display("FAIL hold_stable k=%0d: ctrl %b resp %h chal %h required 1010 %h %h",
                 k, {bus.resp_valid, bus.chal_ready, busy, puf_signal}, bus.resp_out,
                 puf_challenge, hold, c1);
      end
    end
    bus.chal_valid = 1'b0;
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1 bus.resp_ready = 1'b0;
    for (int v = 0; v < VOTES; v++) tab[v] = rand_word();
    puf_response   = tab[0];
    bus.chal_valid = 1'b1;
    exp_q.push_back(vote_model());
    @(negedge clk);
    checks++;
    if ({bus.resp_valid, bus.chal_ready} !== 2'b01) begin
      failures++;
      $display("FAIL b2b_idle: got %b required 01", {bus.resp_valid, bus.chal_ready});
    end
    @(posedge clk);
    #1 bus.chal_valid = 1'b0;
    monitor_eval(c2, got);
    take_resp();
  endtask

  task automatic test_abort(input int abort_e);
    logic [N-1:0] c, got;
    logic exp_sig;
    bit seen;
    c = rand_word();
    for (int v = 0; v < VOTES; v++) tab[v] = rand_word();
    send_chal(c);
    repeat (abort_e) @(posedge clk);
    #2;
    exp_sig = ((abort_e % (2 * SETTLE + 1)) >= SETTLE);
    checks++;
    if (puf_signal !== exp_sig) begin
      failures++;
      $display("FAIL abort_pre_sig e=%0d: got %b required %b", abort_e, puf_signal, exp_sig);
    end
    rst = 1'b1;
    exp_q.delete();
    #1;
    checks++;
    if ({puf_signal, bus.resp_valid, busy, bus.chal_ready} !== 4'b0001 || puf_challenge !== '0) begin
      failures++;
      $display("FAIL abort_reset e=%0d: ctrl %b chal %h required 0001 0",
               abort_e, {puf_signal, bus.resp_valid, busy, bus.chal_ready}, puf_challenge);
    end
    @(negedge clk);
    rst  = 1'b0;
    seen = 1'b0;
    repeat (LATENCY + 20) begin
      @(negedge clk);
      if (bus.resp_valid === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL abort_no_resp e=%0d: got resp_valid required none", abort_e);
    end
    c = rand_word();
    for (int v = 0; v < VOTES; v++) tab[v] = rand_word();
    send_chal(c);
    monitor_eval(c, got);
    take_resp();
  endtask

  initial begin
    test_reset();
    test_all_ones();
    test_majority();
    test_random();
    test_back_to_back();
    test_abort(40);
    test_abort(12);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
